// File: rtl/shifter_arbiter.sv
// shifter_arbiter: two requesters share one 16-bit barrel shifter through a round-robin
// arbiter feeding a single-entry result register with valid/ready handshakes.
module barrel_shifter16 (
  input  logic [15:0] In,
  input  logic [3:0]  ShAmt,
  input  logic        shift_rotate,
  input  logic        left_right,
  output logic [15:0] Out
);
  logic [31:0] dbl_l, dbl_r;
  always_comb begin
    dbl_l = {In, In} << ShAmt;
    dbl_r = {In, In} >> ShAmt;
    Out = left_right ? (shift_rotate ? In << ShAmt : dbl_l[31:16])
                     : (shift_rotate ? In >> ShAmt : dbl_r[15:0]);
  end
endmodule

module shifter_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  input  logic        r1_valid,
  output logic        r0_ready,
  output logic        r1_ready,
  input  logic [15:0] r0_in,
  input  logic [15:0] r1_in,
  input  logic [3:0]  r0_amt,
  input  logic [3:0]  r1_amt,
  input  logic        r0_sr,
  input  logic        r1_sr,
  input  logic        r0_lr,
  input  logic        r1_lr,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_id
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t      state;
  logic        last_grant, grant0, grant1, slot_free, accept;
  logic [15:0] sh_in, sh_out;
  logic [3:0]  sh_amt;
  logic        sh_sr, sh_lr;
  // the requester that did not win last time has priority under contention
  always_comb begin
    grant0    = r0_valid & (~r1_valid | last_grant);
    grant1    = r1_valid & (~r0_valid | ~last_grant);
    slot_free = (state == EMPTY) | res_ready;
    r0_ready  = rst & slot_free & grant0;
    r1_ready  = rst & slot_free & grant1;
    accept    = r0_ready | r1_ready;
    sh_in     = grant1 ? r1_in  : r0_in;
    sh_amt    = grant1 ? r1_amt : r0_amt;
    sh_sr     = grant1 ? r1_sr  : r0_sr;
    sh_lr     = grant1 ? r1_lr  : r0_lr;
  end
  barrel_shifter16 u_shifter (
    .In(sh_in),
    .ShAmt(sh_amt),
    .shift_rotate(sh_sr),
    .left_right(sh_lr),
    .Out(sh_out)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      res_data   <= 16'h0000;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      state      <= FULL;
      res_data   <= sh_out;
      res_id     <= r1_ready;
      last_grant <= r1_ready;
    end else if (res_ready) begin
      state <= EMPTY;
    end
  end
  assign res_valid = (state == FULL);
endmodule

// File: tb/tb_shifter_arbiter.sv
// tb_shifter_arbiter: directed vector table plus hand-written backpressure and reset sequences.
module tb_shifter_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r1_valid, r0_ready, r1_ready;
  logic [15:0] r0_in, r1_in;
  logic [3:0]  r0_amt, r1_amt;
  logic        r0_sr, r1_sr, r0_lr, r1_lr;
  logic        res_valid, res_ready, res_id;
  logic [15:0] res_data;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shifter_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r1_valid(r1_valid),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_in(r0_in), .r1_in(r1_in),
    .r0_amt(r0_amt), .r1_amt(r1_amt),
    .r0_sr(r0_sr), .r1_sr(r1_sr),
    .r0_lr(r0_lr), .r1_lr(r1_lr),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
  );

  typedef struct {
    logic        v0, v1;
    logic [15:0] in0; logic [3:0] amt0; logic sr0, lr0;
    logic [15:0] in1; logic [3:0] amt1; logic sr1, lr1;
    logic        rr;
    logic        e_rd0, e_rd1, e_val, chk_data;
    logic [15:0] e_data;
    logic        e_id;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic rr);
    r0_valid = v0; r1_valid = v1; res_ready = rr;
  endtask

  initial begin
    vecs[0]  = '{1,0, 16'h00FF,4,1,1, 16'h0000,0,0,0, 1, 1,0,1,1, 16'h0FF0,0};
    vecs[1]  = '{0,1, 16'h0000,0,0,0, 16'h0001,4,0,0, 1, 0,1,1,1, 16'h1000,1};
    vecs[2]  = '{1,0, 16'h8001,1,0,1, 16'h0000,0,0,0, 1, 1,0,1,1, 16'h0003,0};
    vecs[3]  = '{0,1, 16'h0000,0,0,0, 16'hA5A5,0,1,0, 1, 0,1,1,1, 16'hA5A5,1};
    vecs[4]  = '{1,0, 16'hFFFF,15,1,1, 16'h0000,0,0,0, 1, 1,0,1,1, 16'h8000,0};
    vecs[5]  = '{0,1, 16'h0000,0,0,0, 16'h8000,15,1,0, 1, 0,1,1,1, 16'h0001,1};
    vecs[6]  = '{0,0, 16'h0000,0,0,0, 16'h0000,0,0,0, 1, 0,0,0,0, 16'h0000,0};
    vecs[7]  = '{1,1, 16'h1234,8,0,1, 16'h00F0,4,1,0, 1, 1,0,1,1, 16'h3412,0};
    vecs[8]  = '{1,1, 16'hF00F,4,1,0, 16'h00F0,4,1,0, 1, 0,1,1,1, 16'h000F,1};
    vecs[9]  = '{1,1, 16'hF00F,4,1,0, 16'h0F0F,2,0,0, 1, 1,0,1,1, 16'h0F00,0};
    vecs[10] = '{1,1, 16'h0000,0,0,0, 16'h0F0F,2,0,0, 1, 0,1,1,1, 16'hC3C3,1};

    rst = 1'b0;
    drive(1, 1, 1);
    r0_in = 16'h1111; r0_amt = 1; r0_sr = 1; r0_lr = 1;
    r1_in = 16'h2222; r1_amt = 1; r1_sr = 1; r1_lr = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_r0_ready", r0_ready, 0);
    chk("reset_r1_ready", r1_ready, 0);
    chk("reset_valid", res_valid, 0);
    chk("reset_data", res_data, 0);
    chk("reset_id", res_id, 0);
    drive(0, 0, 1);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].v1, vecs[i].rr);
      r0_in = vecs[i].in0; r0_amt = vecs[i].amt0; r0_sr = vecs[i].sr0; r0_lr = vecs[i].lr0;
      r1_in = vecs[i].in1; r1_amt = vecs[i].amt1; r1_sr = vecs[i].sr1; r1_lr = vecs[i].lr1;
      #1;
      chk($sformatf("v%0d_r0_ready", i), r0_ready, vecs[i].e_rd0);
      chk($sformatf("v%0d_r1_ready", i), r1_ready, vecs[i].e_rd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_res_valid", i), res_valid, vecs[i].e_val);
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d_res_data", i), res_data, vecs[i].e_data);
        chk($sformatf("v%0d_res_id", i), res_id, vecs[i].e_id);
      end
    end

    // backpressure: r0 result held while consumer stalls, r1 waits
    @(negedge clk);
    drive(1, 0, 1);
    r0_in = 16'h00FF; r0_amt = 4; r0_sr = 1; r0_lr = 1;
    @(posedge clk); #1;
    chk("bp_load_data", res_data, 16'h0FF0);
    @(negedge clk);
    drive(0, 1, 0);
    r1_in = 16'h0001; r1_amt = 4; r1_sr = 0; r1_lr = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_r0_ready", r0_ready, 0);
      chk("bp_r1_ready", r1_ready, 0);
      @(posedge clk); #1;
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 16'h0FF0);
      chk("bp_id", res_id, 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_r1_ready", r1_ready, 1);
    @(posedge clk); #1;
    chk("bp_release_valid", res_valid, 1);
    chk("bp_release_data", res_data, 16'h1000);
    chk("bp_release_id", res_id, 1);

    // reset while FULL and stalled, then contention must go to r0
    @(negedge clk);
    drive(0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", res_valid, 0);
    chk("midrst_data", res_data, 0);
    chk("midrst_id", res_id, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 1);
    r0_in = 16'hA5A5; r0_amt = 0; r0_sr = 0; r0_lr = 0;
    r1_in = 16'h0001; r1_amt = 1; r1_sr = 1; r1_lr = 1;
    #1;
    chk("midrst_r0_ready", r0_ready, 1);
    chk("midrst_r1_ready", r1_ready, 0);
    @(posedge clk); #1;
    chk("midrst_res_data", res_data, 16'hA5A5);
    chk("midrst_res_id", res_id, 0);
    @(negedge clk);
    drive(0, 0, 1);
    @(posedge clk); #1;
    chk("drain_valid", res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
